// File: rtl/eindopdracht_nios2_gen2_0_cpu_debug_ocimem.sv
// On-chip debug memory stage. Owns a 2^ADDR_W x DATA_W debug RAM shared between
// JTAG host accesses (driven by jdo and the take_*_ocimem_* strobes, already in
// the clk domain) and a CPU-side Avalon-MM slave port.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   jdo                           JTAG data word (address, read flag, write data)
//   take_action_ocimem_a          load address; optionally queue a read
//   take_no_action_ocimem_a       queue a read at current address, then increment
//   take_action_ocimem_b          queue a write at current address, then increment
//   avs_*                         CPU Avalon-MM slave (word addressed, byte enables)
//   MonDReg                       data returned by the last JTAG read
//   monitor_ready                 no JTAG operation pending
//   monitor_error                 sticky JTAG overrun / dropped strobe flag
module eindopdracht_nios2_gen2_0_cpu_debug_ocimem #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic [ADDR_W-1:0]     avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [DATA_W-1:0]     avs_writedata,
  input  logic [DATA_W/8-1:0]   avs_byteenable,
  output logic [DATA_W-1:0]     avs_readdata,
  output logic                  avs_waitrequest,
  output logic [DATA_W-1:0]     MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned NumBytes = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StJrd, StJwr, StCrd} state_e;
  typedef enum logic [1:0] {KindRd, KindRdInc, KindWr} jkind_e;

  state_e              state_q, state_d;
  jkind_e              jkind_q, jkind_d;
  logic [ADDR_W-1:0]   mon_a_reg_q, mon_a_reg_d;
  logic [DATA_W-1:0]   mon_d_reg_q, mon_d_reg_d;
  logic [DATA_W-1:0]   jwdata_q, jwdata_d;
  logic                jpend_q, jpend_d;
  logic                error_q, error_d;

  logic [DATA_W-1:0]   mem_q [Depth];
  logic [DATA_W-1:0]   ram_rdata_q;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [NumBytes-1:0] ram_be;
  logic                ram_we;
  logic                cpu_wr_go;

  // Bits of jdo that carry nothing for this stage.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // A CPU write only proceeds from IDLE when no JTAG op is waiting for the RAM.
  assign cpu_wr_go = (state_q == StIdle) && !jpend_q && avs_write;

  // Single RAM port: JTAG address whenever a JTAG op owns the port.
  always_comb begin
    ram_addr  = mon_a_reg_q;
    ram_wdata = jwdata_q;
    ram_be    = '1;
    ram_we    = 1'b0;
    if (state_q == StJwr) begin
      ram_we = 1'b1;
    end else if (state_q == StIdle && !jpend_q) begin
      ram_addr  = avs_address;
      ram_wdata = avs_writedata;
      ram_be    = avs_byteenable;
      ram_we    = avs_write;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (ram_be[b]) mem_q[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    ram_rdata_q <= mem_q[ram_addr];
  end

  always_comb begin
    state_d     = state_q;
    jkind_d     = jkind_q;
    mon_a_reg_d = mon_a_reg_q;
    mon_d_reg_d = mon_d_reg_q;
    jwdata_d    = jwdata_q;
    jpend_d     = jpend_q;
    error_d     = error_q;

    unique case (state_q)
      StIdle: begin
        if (jpend_q) begin
          state_d = (jkind_q == KindWr) ? StJwr : StJrd;
        end else if (avs_read && !avs_write) begin
          state_d = StCrd;
        end
      end
      StJrd: begin
        mon_d_reg_d = ram_rdata_q;
        jpend_d     = 1'b0;
        if (jkind_q == KindRdInc) mon_a_reg_d = mon_a_reg_q + ADDR_W'(1);
        state_d     = StIdle;
      end
      StJwr: begin
        jpend_d     = 1'b0;
        mon_a_reg_d = mon_a_reg_q + ADDR_W'(1);
        state_d     = StIdle;
      end
      StCrd: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Strobe priority a > b > no_action. Losers, and anything that would queue
    // on top of a pending op, are dropped and flagged. The error set is applied
    // after the clear so a dropped companion strobe still shows up.
    if (take_action_ocimem_a) begin
      if (jdo[17] && jpend_q) begin
        error_d = 1'b1;
      end else begin
        mon_a_reg_d = jdo[18 +: ADDR_W];
        error_d     = 1'b0;
        if (jdo[17]) begin
          jpend_d = 1'b1;
          jkind_d = KindRd;
        end
      end
      if (take_action_ocimem_b || take_no_action_ocimem_a) error_d = 1'b1;
    end else if (take_action_ocimem_b) begin
      if (jpend_q) begin
        error_d = 1'b1;
      end else begin
        jwdata_d = jdo[34:3];
        jpend_d  = 1'b1;
        jkind_d  = KindWr;
      end
      if (take_no_action_ocimem_a) error_d = 1'b1;
    end else if (take_no_action_ocimem_a) begin
      if (jpend_q) begin
        error_d = 1'b1;
      end else begin
        jpend_d = 1'b1;
        jkind_d = KindRdInc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      jkind_q     <= KindRd;
      mon_a_reg_q <= '0;
      mon_d_reg_q <= '0;
      jwdata_q    <= '0;
      jpend_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      jkind_q     <= jkind_d;
      mon_a_reg_q <= mon_a_reg_d;
      mon_d_reg_q <= mon_d_reg_d;
      jwdata_q    <= jwdata_d;
      jpend_q     <= jpend_d;
      error_q     <= error_d;
    end
  end

  assign avs_readdata    = (state_q == StCrd) ? ram_rdata_q : '0;
  assign avs_waitrequest = (avs_read | avs_write) & ~(cpu_wr_go | (state_q == StCrd));
  assign MonDReg         = mon_d_reg_q;
  assign monitor_ready   = ~jpend_q;
  assign monitor_error   = error_q;

endmodule

// File: doc/eindopdracht_nios2_gen2_0_cpu_debug_ocimem.md
# eindopdracht_nios2_gen2_0_cpu_debug_ocimem

On-chip debug memory stage directly downstream of the debug-slave wrapper. It consumes `jdo` and the `take_*_ocimem_*` strobes, which are already synchronised to `clk`. It owns a 256×32 debug RAM that is shared between JTAG host accesses and a CPU-side Avalon-MM slave port. It returns `MonDReg`, `monitor_ready` and `monitor_error` back upstream.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width; RAM depth is 2^ADDR_W.
- `DATA_W`, 32: data width; fixed by `jdo`/`MonDReg`, do not override.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `jdo`  in  38  JTAG data word from the debug slave.
- `take_action_ocimem_a`  in  1  one-cycle strobe: load address, optional read.
- `take_no_action_ocimem_a`  in  1  one-cycle strobe: read at current address, then increment.
- `take_action_ocimem_b`  in  1  one-cycle strobe: write at current address, then increment.
- `avs_address`  in  8  CPU word address.
- `avs_read`, `avs_write`  in  1  CPU request.
- `avs_writedata`  in  32  CPU write data.
- `avs_byteenable`  in  4  CPU byte lanes.
- `avs_readdata`  out  32  CPU read data.
- `avs_waitrequest`  out  1  Avalon wait.
- `MonDReg`  out  32  last JTAG read data.
- `monitor_ready`  out  1  no JTAG operation pending.
- `monitor_error`  out  1  sticky JTAG overrun flag.

## Operation
- Registers:
  - `MonAReg[7:0]`: JTAG address.
  - `jpend`: JTAG op pending.
  - `jkind`: read / read-increment / write.
  - `jwdata[31:0]`.
- Field map for `jdo`:
  - `take_action_ocimem_a`: `MonAReg <= jdo[25:18]`. If `jdo[17]=1`, queue a read *without* increment. Always clears `monitor_error`.
  - `take_no_action_ocimem_a`: queue a read *with* increment.
  - `take_action_ocimem_b`: `jwdata <= jdo[34:3]`; queue a write with increment.
- Simultaneous strobes:
  - Priority is a > b > no_action.
  - Dropped strobes set `monitor_error`.
  - A strobe that would queue while `jpend=1` is dropped and sets `monitor_error`. An address load with `jdo[17]=0` is still accepted.
- `monitor_ready = ~jpend`.
- FSM states: IDLE, JRD, JWR, CRD.
  - IDLE, `jpend` set → JRD (RAM read issued at `MonAReg`) or JWR. JTAG has priority over CPU.
  - IDLE, no `jpend`, `avs_write` → write RAM with `avs_byteenable` this cycle; stay IDLE.
  - IDLE, no `jpend`, `avs_read` → CRD (RAM read issued at `avs_address`).
  - JRD: `MonDReg <= q`; clear `jpend`; increment if kind=read-increment → IDLE.
  - JWR: write `jwdata`, all byte lanes; clear `jpend`; increment → IDLE.
  - CRD: `avs_readdata = q` → IDLE.
- An in-progress CPU access is never pre-empted. A JTAG op queued during CRD starts in the next IDLE cycle.
- `MonAReg` increments modulo 256: 8'hFF → 8'h00.
- RAM: synchronous read, 1-cycle latency, single port, not reset.

## Timing
- Reset values: `MonDReg=0`, `MonAReg=0`, `monitor_ready=1`, `monitor_error=0`, `avs_readdata=0`, `jpend=0`, state IDLE.
  - `avs_waitrequest` is combinational, so it is 0 during reset unless a request is present.
- `avs_waitrequest = (avs_read|avs_write) & ~done`, where `done` is:
  - IDLE & `avs_write` & ~`jpend`; or
  - CRD.
- CPU write: 1 cycle with no contention.
- CPU read: 2 cycles, waitrequest high on cycle 0 and low on cycle 1 with data valid.
- JTAG read: strobe at edge N → `jpend=1` after N → JRD at N+1 → `MonDReg` valid and `monitor_ready=1` after N+2.
- JTAG write: RAM updated at the N+2 edge; `monitor_ready=1` after N+2.
- CPU waitrequest is held for every cycle that the JTAG op occupies the RAM.
- `reset_n` low mid-operation: all registers clear immediately and the pending op is lost. RAM holds any write already committed.
- Reset deassertion is synchronised upstream; this block samples `reset_n` only as an async clear.

## Test plan
- Reset: `reset_n=0` for 3 cycles → `monitor_ready=1`, `monitor_error=0`, `MonDReg=0`, `avs_waitrequest=0`.
- JTAG write then read:
  - `take_action_ocimem_a`, `jdo[25:18]=8'h10`, `jdo[17]=0`.
  - `take_action_ocimem_b` with data 32'hDEADBEEF.
  - Reload `jdo[25:18]=8'h10` with `jdo[17]=1`.
  - Expect `MonDReg=32'hDEADBEEF` two cycles after the strobe, and `MonAReg=8'h10`.
- Wrap: set address 8'hFF, then JTAG write → `MonAReg=8'h00`. A CPU read at 8'hFF returns the written word after 2 cycles.
- Contention: CPU read issued the same cycle a JTAG write is pending → JTAG write completes first; CPU waitrequest high for 3 cycles total; read data reflects the write if the addresses match.
- Overrun: a second `take_no_action_ocimem_a` while `jpend=1` → `monitor_error=1`, first op completes normally; a later `take_action_ocimem_a` clears `monitor_error`.
- Byte enables and reset mid-op:
  - CPU write 32'h11223344 with byteenable 4'b0101 over 32'hFFFFFFFF → readback 32'hFF22FF44.
  - `reset_n` pulsed low between the strobe and JRD → `MonDReg=0`, `monitor_ready=1`.
